knn_local_sp_arbiter: RTL and testbench

KNN_LOCAL_SP_ARBITER -- requirements
Module: knn_local_sp_arbiter

---
 rtl/knn_sp_arb_pkg.sv | 12 +
 rtl/knn_sp_rd_valid_pipe.sv | 27 ++
 rtl/knn_local_sp_arbiter.sv | 123 ++++++++++++
 tb/tb_knn_local_sp_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_sp_arb_pkg.sv
// Shared types for the KNN local-buffer single-port arbiter: owner-state
// encoding and burst counter width.
package knn_sp_arb_pkg;

  localparam int BURST_W = 8;

  typedef enum logic [0:0] {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

endpackage

// File: rtl/knn_sp_rd_valid_pipe.sv
// Read-valid delay line: carries each read grant forward DEPTH cycles so the
// valid strobe lines up with the URAM output.
module knn_sp_rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_in,
  output logic shift_out
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign shift_out = sr[DEPTH-1];

endmodule

// File: rtl/knn_local_sp_arbiter.sv
// Arbitrates a loader (writes) and a compute engine (reads) onto one URAM port
// with owner-preference bursts. Optional conflict counter: KNN_SP_ARB_STATS_EN.
module knn_local_sp_arbiter
  import knn_sp_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0,
  output owner_e                owner_state,
  output logic [BURST_W-1:0]    burst_cnt
`ifdef KNN_SP_ARB_STATS_EN
  ,
  output logic [31:0]           conflict_cnt
`endif
);

  // Handshake: a requester holds req/addr/data until it sees gnt high in the
  // same cycle; the transfer happens on that clock edge. rd_valid is never
  // back-pressured.

  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

  owner_e             state, state_next;
  logic [BURST_W-1:0] cnt, cnt_next;
  logic               both, at_limit, wr_wins, valid_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OWN_WR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Grants: owner wins a conflict unless it has used its whole burst.
  always_comb begin
    both     = wr_req & rd_req;
    at_limit = (cnt == BURST_LIMIT);
    wr_wins  = (state == OWN_WR) ? !at_limit : at_limit;
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    if (!reset) begin
      if (both) begin
        wr_gnt = wr_wins;
        rd_gnt = !wr_wins;
      end else begin
        wr_gnt = wr_req;
        rd_gnt = rd_req;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (wr_gnt) begin
      if (state == OWN_WR) begin
        cnt_next = at_limit ? cnt : cnt + BURST_W'(1);
      end else begin
        state_next = OWN_WR;
        cnt_next   = BURST_W'(1);
      end
    end else if (rd_gnt) begin
      if (state == OWN_RD) begin
        cnt_next = at_limit ? cnt : cnt + BURST_W'(1);
      end else begin
        state_next = OWN_RD;
        cnt_next   = BURST_W'(1);
      end
    end
  end

  assign mem_ce0      = wr_gnt | rd_gnt;
  assign mem_we0      = wr_gnt;
  assign mem_address0 = wr_gnt ? wr_addr : rd_addr;
  assign mem_d0       = wr_data;

  knn_sp_rd_valid_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_valid_pipe (
    .clk      (clk),
    .reset    (reset),
    .shift_in (rd_gnt),
    .shift_out(valid_raw)
  );

  // Gate with reset so a read already at the last stage is dropped too.
  assign rd_valid    = valid_raw & ~reset;
  assign rd_data     = mem_q0;
  assign owner_state = state;
  assign burst_cnt   = cnt;

`ifdef KNN_SP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (both && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Bench for knn_local_sp_arbiter: URAM model, directed scenarios and random
// traffic checked every cycle against a behavioural arbitration/memory model.
module tb_knn_local_sp_arbiter;
  import knn_sp_arb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int MB  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0, mem_we0;
  logic [DW-1:0] mem_d0, mem_q0;
  owner_e        owner_state;
  logic [7:0]    burst_cnt;
`ifdef KNN_SP_ARB_STATS_EN
  logic [31:0]   conflict_cnt;
  int            m_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  knn_local_sp_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0),
    .owner_state(owner_state), .burst_cnt(burst_cnt)
`ifdef KNN_SP_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // URAM: synchronous write, read data appears LAT cycles after the request.
  logic [DW-1:0] uram [2**AW];
  logic [DW-1:0] q_pipe [LAT];
  initial begin
    for (int i = 0; i < 2**AW; i++) uram[i] = '0;
    for (int i = 0; i < LAT; i++) q_pipe[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) uram[mem_address0] <= mem_d0;
    if (mem_ce0 && !mem_we0) q_pipe[0] <= uram[mem_address0];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q0 = q_pipe[LAT-1];

  // Behavioural model: who owns the port, how long its current run is,
  // a shadow of memory contents, and reads still due to return.
  bit            m_owner_wr = 1'b1;
  int            m_run = 0;
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  int            cyc = 0;

  // Observations of the last cycle, for directed literal checks.
  logic          o_wr_gnt, o_rd_gnt, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] seen_data[$];
  int            seen_cyc[$];

  initial for (int i = 0; i < 2**AW; i++) shadow[i] = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare at the falling edge, update the model, return just
  // after the next rising edge ready for new inputs.
  task automatic cycle();
    bit ew, er, ev;
    @(negedge clk);
    cyc++;
    ew = 1'b0;
    er = 1'b0;
    if (!reset) begin
      if (wr_req && rd_req) begin
        ew = (m_run >= MB) ? !m_owner_wr : m_owner_wr;
        er = !ew;
      end else begin
        ew = wr_req;
        er = rd_req;
      end
    end
    ev = !reset && (due_q.size() > 0) && (due_q[0] == cyc);
    chk("wr_gnt", 64'(wr_gnt), 64'(ew));
    chk("rd_gnt", 64'(rd_gnt), 64'(er));
    chk("mem_ce0", 64'(mem_ce0), 64'(ew | er));
    chk("mem_we0", 64'(mem_we0), 64'(ew));
    if (ew | er) chk("mem_address0", 64'(mem_address0), 64'(ew ? wr_addr : rd_addr));
    if (ew) chk("mem_d0", 64'(mem_d0), 64'(wr_data));
    chk("owner", 64'(owner_state), 64'(m_owner_wr ? OWN_WR : OWN_RD));
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev) begin
      chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
`ifdef KNN_SP_ARB_STATS_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conflict));
    if (reset) m_conflict = 0;
    else if (wr_req && rd_req && m_conflict != 32'hFFFF_FFFF) m_conflict++;
`endif
    o_wr_gnt = wr_gnt;
    o_rd_gnt = rd_gnt;
    o_we     = mem_we0;
    o_addr   = mem_address0;
    if (rd_valid) begin
      seen_data.push_back(rd_data);
      seen_cyc.push_back(cyc);
    end
    if (reset) begin
      m_owner_wr = 1'b1;
      m_run = 0;
      exp_q.delete();
      due_q.delete();
    end else if (ew) begin
      shadow[wr_addr] = wr_data;
      if (m_owner_wr) m_run = (m_run < MB) ? m_run + 1 : MB;
      else begin m_owner_wr = 1'b1; m_run = 1; end
    end else if (er) begin
      exp_q.push_back(shadow[rd_addr]);
      due_q.push_back(cyc + LAT);
      if (!m_owner_wr) m_run = (m_run < MB) ? m_run + 1 : MB;
      else begin m_owner_wr = 1'b0; m_run = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_req = 1'b0;
    rd_req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int g;
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    do_reset(2);
    chk("reset_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("reset_owner", 64'(owner_state), 64'(OWN_WR));

    // Writer alone: four back-to-back writes of 0xA0..0xA3.
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'hA0 + i);
      cycle();
      chk("w_alone_gnt", 64'(o_wr_gnt), 64'd1);
      chk("w_alone_we", 64'(o_we), 64'd1);
      chk("w_alone_addr", 64'(o_addr), 64'(i));
    end
    wr_req = 1'b0;

    // Reader alone: data returns LAT cycles after each grant, in order.
    seen_data.delete(); seen_cyc.delete();
    g = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      cycle();
      chk("r_alone_gnt", 64'(o_rd_gnt), 64'd1);
    end
    idle(4);
    chk("r_alone_count", 64'(seen_data.size()), 64'd4);
    for (int i = 0; i < seen_data.size() && i < 4; i++) begin
      chk("r_alone_data", 64'(seen_data[i]), 64'(8'hA0 + i));
      chk("r_alone_lat", 64'(seen_cyc[i]), 64'(g + i + LAT));
    end

    // Both continuous from reset: W x4, R x4, W x4.
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      wr_req = 1'b1; rd_req = 1'b1;
      wr_addr = AW'(8 + (k % 8)); wr_data = DW'(k); rd_addr = AW'(k % 4);
      cycle();
      chk("burst_pattern_w", 64'(o_wr_gnt), 64'(((k / 4) % 2) == 0));
    end
    idle(LAT + 1);

    // Write-then-read hazard on address 5.
    seen_data.delete(); seen_cyc.delete();
    wr_req = 1'b1; wr_addr = AW'(5); wr_data = DW'(8'h55);
    cycle();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = AW'(5);
    cycle();
    g = cyc;
    idle(LAT + 1);
    chk("raw_count", 64'(seen_data.size()), 64'd1);
    if (seen_data.size() > 0) begin
      chk("raw_data", 64'(seen_data[0]), 64'h55);
      chk("raw_lat", 64'(seen_cyc[0]), 64'(g + LAT));
    end

    // Reset one cycle after a read grant drops the read.
    rd_req = 1'b1; rd_addr = AW'(1);
    cycle();
    seen_data.delete(); seen_cyc.delete();
    reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_wr_gnt", 64'(o_wr_gnt), 64'd0);
      chk("rst_rd_gnt", 64'(o_rd_gnt), 64'd0);
    end
    reset = 1'b0;
    chk("rst_owner", 64'(owner_state), 64'(OWN_WR));
    idle(LAT + 2);
    chk("rst_dropped", 64'(seen_data.size()), 64'd0);

`ifdef KNN_SP_ARB_STATS_EN
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      wr_req = 1'b1; rd_req = 1'b1;
      cycle();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    #3;
    chk("conflict_10", 64'(conflict_cnt), 64'd10);
    do_reset(1);
    #3;
    chk("conflict_clr", 64'(conflict_cnt), 64'd0);
`endif

    // Random traffic with hold-until-grant requesters and sparse resets.
    wr_req = 1'b0; rd_req = 1'b0;
    o_wr_gnt = 1'b0; o_rd_gnt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!wr_req || o_wr_gnt) begin
        wr_req  = ($urandom_range(0, 99) < 60);
        wr_addr = AW'($urandom_range(0, 2**AW - 1));
        wr_data = DW'($urandom);
      end
      if (!rd_req || o_rd_gnt) begin
        rd_req  = ($urandom_range(0, 99) < 55);
        rd_addr = AW'($urandom_range(0, 2**AW - 1));
      end
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(LAT + 2);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
